addsub_serial_ctrl: RTL and testbench
=====================================

Name: addsub_serial_ctrl

Overview:
Nibble-serial controller that sequences one 4-bit add/sub slice across NIBBLES cycles to form a 4*NIBBLES-bit add or subtract. It chains the carry between nibbles and injects op as carry-in, so subtract is a + ~b + 1. It uses a valid/ready handshake on both sides. The result is held until the consumer accepts it. It sits between operand sources and the result consumer, so the wide operation needs only one 4-bit slice.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; operand/result width W = 4*NIBBLES (min 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/op presented
in_ready  output  1  controller can accept operands
op  input  1  0 = add, 1 = subtract (a - b)
a  input  W  operand A, two's complement
b  input  W  operand B, two's complement
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  W  a+b or a-b, modulo 2^W
c_out  output  1  carry out of bit W-1 (for subtract, 1 = no borrow)
ovf  output  1  signed overflow
busy  output  1  high in CALC or HOLD

Behaviour:
- Reset (rst_n=0 at a clk edge, any state):
  - state <= IDLE; result, c_out, ovf, out_valid, nibble index, carry <= 0.
  - in_ready=1 and busy=0 from the next cycle.
  - Reset in the middle of a transaction discards it; no partial result is ever flagged valid.
- States: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1, busy=0, out_valid=0.
  - On in_valid & in_ready at an edge: latch a, b and op into internal registers; carry <= op; idx <= 0; go to CALC.
  - result keeps its previous value until overwritten.
- CALC:
  - in_ready=0, busy=1.
  - Each cycle: {cy, s} = A[idx] + (B[idx] ^ {4{op}}) + carry. Write s to result nibble idx. carry <= cy. idx <= idx+1.
  - Input ports are ignored; only the latched copies are used.
  - When idx = NIBBLES-1: c_out <= cy. ovf <= carry into bit W-1 XOR cy. Go to HOLD.
- HOLD:
  - out_valid=1, busy=1, in_ready=0.
  - result, c_out and ovf stay stable while out_ready=0, for any number of cycles.
  - On out_valid & out_ready at an edge: out_valid <= 0; go to IDLE.
  - There is no same-cycle re-accept: in_ready rises the cycle after the handshake. A simultaneous in_valid is ignored until then.
- Latency: accept edge at cycle k, out_valid high after edge k+NIBBLES. Minimum initiation interval is NIBBLES+2 cycles.
- Width and arithmetic: all sums are modulo 2^W.
  - ovf = 1 only when both operands, as effectively added (b inverted for subtract), have the same sign and result has the opposite sign.
  - Nibble carry chain: bit 3 of nibble i carries into bit 0 of nibble i+1.
- Outputs are registered: out_valid, in_ready and busy are decoded from the state register only, with no combinational path from inputs.

Test Plan:
1. NIBBLES=4, op=0, a=0x0005, b=0x0003, out_ready=1 -> out_valid exactly 4 cycles after accept; result=0x0008, c_out=0, ovf=0; in_ready back to 1 the cycle after the handshake.
2. op=1, a=0x0005, b=0x0006 -> result=0xFFFF (-1), c_out=0 (borrow), ovf=0. Then op=1, a=0x0006, b=0x0005 -> result=0x0001, c_out=1.
3. op=0, a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, c_out=0; the carry ripples through all 4 nibbles. Also op=1, a=0x8000, b=0x0001 -> result=0x7FFF, ovf=1.
4. op=0, a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1, ovf=0. Also a=0x00F0, b=0x0010 -> 0x0100, which checks the nibble-boundary carry.
5. Backpressure: out_ready=0 for 5 cycles in HOLD. a, b and op change and in_valid pulses during CALC/HOLD -> result and flags are bit-stable, in_ready=0, the changes have no effect, and no second transaction is accepted. Raising out_ready completes exactly one handshake.
6. rst_n=0 for one edge 2 cycles into CALC -> next cycle state IDLE, out_valid=0, result=0, busy=0, in_ready=1. A following add 0x1234+0x1111 -> 0x2345 with correct latency.

Source files
------------

// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial add/sub: one 4-bit slice, chained carry, op injected as carry-in.
// Latency: out_valid rises NIBBLES cycles after the accept edge.
// Backpressure: result and flags hold in HOLD until out_ready; in_ready low while busy.
module addsub_serial_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);

  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            op_q, op_d;
  logic [W-1:0]    result_q, result_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib_x;
  logic [4:0]      nib_sum;

  // Slice operands come only from the latched copies, never the input ports.
  always_comb begin
    a_nib   = a_q[{idx_q, 2'b00} +: 4];
    b_nib_x = b_q[{idx_q, 2'b00} +: 4] ^ {4{op_q}};
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib_x} + {4'b0000, carry_q};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    carry_d  = carry_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        result_d[{idx_q, 2'b00} +: 4] = nib_sum[3:0];
        carry_d = nib_sum[4];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          c_out_d = nib_sum[4];
          // Carry into the MSB is recovered from the MSB sum bit.
          ovf_d   = (a_nib[3] ^ b_nib_x[3] ^ nib_sum[3]) ^ nib_sum[4];
          idx_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
    end
  end

  // Handshake outputs decode the state register only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl: directed vectors, expected results queued at issue
// and checked by an independent monitor on each output handshake.
module tb_addsub_serial_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   sent = 0;
  int   hs_count = 0;

  addsub_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Issue one transaction; the expected response is queued only when asked for.
  task automatic send(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] er, input logic ec, input logic eo,
                      input bit expect_it);
    int n;
    exp_t e;
    if (expect_it) begin
      e.r = er; e.c = ec; e.o = eo;
      exp_q.push_back(e);
      sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: tracks accepts, latency, HOLD stability and scoreboard compares.
  initial begin : monitor
    bit           prev_vld;
    bit           prev_hs;
    bit           hs;
    bit           chk_rdy;
    logic [W-1:0] prev_res;
    logic         prev_c;
    logic         prev_o;
    int           acc;
    exp_t         e;
    prev_vld = 0; prev_hs = 0; chk_rdy = 0;
    prev_res = '0; prev_c = 0; prev_o = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_vld = 0; prev_hs = 0; chk_rdy = 0;
      end else begin
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (chk_rdy) check("in_ready_after_hs", 32'(in_ready), 32'd1);
        chk_rdy = 0;
        if (out_valid && !prev_vld) begin
          if (acc_q.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end else begin
            acc = acc_q.pop_front();
            check("latency", 32'(cyc - acc), 32'(NIBBLES));
          end
        end
        if (out_valid) begin
          check("hold_in_ready", 32'(in_ready), 32'd0);
          check("hold_busy", 32'(busy), 32'd1);
        end
        if (out_valid && prev_vld && !prev_hs) begin
          check("hold_result_stable", 32'(result), 32'(prev_res));
          check("hold_flags_stable", {30'd0, c_out, ovf}, {30'd0, prev_c, prev_o});
        end
        hs = out_valid && out_ready;
        if (hs) begin
          hs_count++;
          chk_rdy = 1;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(result), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(result), 32'(e.r));
            check("c_out", 32'(c_out), 32'(e.c));
            check("ovf", 32'(ovf), 32'(e.o));
          end
        end
        prev_vld = out_valid; prev_hs = hs;
        prev_res = result; prev_c = c_out; prev_o = ovf;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_flags", {30'd0, c_out, ovf}, 32'd0);

    // Basic add, subtracts with and without borrow.
    send(1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 1'b0, 1);
    drain();
    send(1'b1, 16'h0005, 16'h0006, 16'hFFFF, 1'b0, 1'b0, 1);
    send(1'b1, 16'h0006, 16'h0005, 16'h0001, 1'b1, 1'b0, 1);
    drain();
    // Signed overflow in both directions; full ripple.
    send(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1);
    send(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1);
    drain();
    // Wraparound and nibble-boundary carry.
    send(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1);
    send(1'b0, 16'h00F0, 16'h0010, 16'h0100, 1'b0, 1'b0, 1);
    drain();

    // Backpressure: inputs wiggle during CALC/HOLD, consumer stalls 5 cycles.
    out_ready = 1'b0;
    send(1'b0, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); op = ~op;
      in_valid = i[0];
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(posedge clk); #1;

    // Reset two cycles into CALC discards the transaction.
    send(1'b0, 16'h0F0F, 16'h0101, 16'h0000, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_q.delete();
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_result", 32'(result), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    send(1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1);
    drain();
    repeat (3) @(posedge clk);
    #1;

    check("pending_expected", 32'(exp_q.size()), 32'd0);
    check("handshake_count", 32'(hs_count), 32'(sent));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
